inv_mix_columns_iter: RTL and testbench
=======================================

# inv_mix_columns_iter

Iterative AES InvMixColumns stage for the decryption datapath: the inverse of the forward MixColumns pipeline stage. It accepts one 128-bit state through a valid/ready handshake and computes one column per cycle through a shared GF(2^8) multiply-by-{0e,0b,0d,09} unit. It holds the result until downstream accepts it. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse-cipher round.

## Interface
- DATA_W, 128, state width; only 128 is supported.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  upstream block valid.
- data_in  in  DATA_W  input state. Byte k is at [127-8k -: 8]. Column c is bytes 4c..4c+3, and byte 4c is row 0.
- ready_out  out  1  block can accept input; combinational, equal to (state==IDLE).
- valid_out  out  1  data_out holds a finished block.
- data_out  out  DATA_W  result state, same byte ordering as data_in.
- ready_in  in  1  downstream accepts data_out.

## Operation
- Input fire: valid_in & ready_out at a rising edge. On fire, latch data_in into an internal state register, clear the column counter col[1:0], and move IDLE->CALC.
- Output fire: valid_out & ready_in at a rising edge.
- FSM states: IDLE, CALC, DONE.
  - IDLE: ready_out=1. Stays in IDLE until input fire.
  - CALC: each edge writes output column col into data_out bytes 4col..4col+3, then col increments. The edge that writes col=3 moves to DONE and sets valid_out=1. col wraps 3->0.
  - DONE: data_out and valid_out hold stable. On output fire, clear valid_out and move to IDLE. data_out keeps its last value.
- Column math, with s0..s3 the column bytes and all products in GF(2^8) mod x^8+x^4+x^3+x+1 (0x11b):
  - o0 = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3
  - o1 = 09·s0 ^ 0e·s1 ^ 0b·s2 ^ 0d·s3
  - o2 = 0d·s0 ^ 09·s1 ^ 0e·s2 ^ 0b·s3
  - o3 = 0b·s0 ^ 0d·s1 ^ 09·s2 ^ 0e·s3
- Products are built from chained xtime: x2 = (b<<1) ^ (b[7] ? 8'h1b : 0), then x4 and x8. Each product uses 8-bit truncation at every step.
- valid_in while not in IDLE is ignored, with no capture. data_in changes while ready_out=0 have no effect.
- Data is never dropped. Upstream must hold valid_in/data_in until fire.

## Timing
- Reset values: state=IDLE, col=0, valid_out=0, data_out=0. ready_out reads 1 as soon as reset asserts, because it is combinational from state.
- Reset mid-CALC or mid-DONE returns to IDLE immediately. The partial block is discarded and valid_out drops asynchronously.
- Latency: with input fire at edge E0, columns 0..3 are written at E1..E4, and valid_out=1 from E4.
- Throughput: with ready_in held high, output fire occurs at E5 and ready_out=1 after E5, so the next accept is at E6. One block completes every 6 cycles.
- There is no simultaneous accept/output in DONE: ready_out=0 there by definition.
- ready_in low in DONE stalls indefinitely, and data_out stays bit-stable.

## Configuration
- INV_MIX_PARALLEL_EN defined: four multiply units; all four columns are computed in one CALC cycle.
  - Latency is 1 edge, so valid_out=1 at E1. Output fires at E2 with ready_in high.
  - col is unused.
- INV_MIX_PARALLEL_EN undefined: the single shared unit and 4-cycle iteration described above.
- Interface, byte ordering, handshake and reset behaviour are identical in both builds.

## Test plan
- FIPS-197 vector: data_in = 8e4da1bc_9fdc589d_01010101_c6c6c6c6 accepted at E0 -> data_out = db135345_f20a225c_01010101_c6c6c6c6 with valid_out rising at E4 (E1 in parallel build).
- Second vector: d5d5d7d6_4d7ebdf8_00000000_ffffffff -> d4d4d4d5_2d26314c_00000000_ffffffff.
- Backpressure: hold ready_in=0 for 10 cycles after valid_out. Required: data_out stable, ready_out=0, and a new valid_in ignored. Raise ready_in: valid_out falls next edge and ready_out=1.
- Back-to-back: assert valid_in continuously with ready_in=1 and two blocks. Required: the second is accepted exactly 6 cycles after the first and both results are correct.
- Reset mid-op: assert reset after E2. Required: valid_out=0, data_out=0 and ready_out=1 immediately. A block sent after release completes correctly.
- Round trip: random blocks through the forward MixColumns then this block -> output equals original input for 1000 blocks.

Source files
------------

// File: rtl/inv_mix_columns_iter.sv
// inv_mix_columns_iter: iterative AES InvMixColumns stage.
// Accepts one 128-bit state, produces the InvMixColumns result one column
// per cycle through a shared GF(2^8) multiply unit, then holds it for
// downstream.
// Build option: define INV_MIX_PARALLEL_EN to use four column units and
// finish the whole state in a single CALC cycle.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; the sender holds valid and data stable until that edge,
// and ready never depends on valid in the same cycle.
module inv_mix_columns_iter #(
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              ready_out,
   output logic              valid_out,
   output logic [DATA_W-1:0] data_out,
   input  logic              ready_in,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            st_q;
   state_t            st_d;
   logic [DATA_W-1:0] blk_q;

   // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant using chained xtime terms
   function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return ({8{k[0]}} & b) ^ ({8{k[1]}} & x2) ^
             ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
   endfunction

   // One InvMixColumns column; byte s0 (row 0) is the MSB
   function automatic logic [31:0] inv_col(input logic [31:0] c);
      logic [7:0] s0;
      logic [7:0] s1;
      logic [7:0] s2;
      logic [7:0] s3;
      s0 = c[31:24];
      s1 = c[23:16];
      s2 = c[15:8];
      s3 = c[7:0];
      return {gmul(s0, 4'he) ^ gmul(s1, 4'hb) ^ gmul(s2, 4'hd) ^ gmul(s3, 4'h9),
              gmul(s0, 4'h9) ^ gmul(s1, 4'he) ^ gmul(s2, 4'hb) ^ gmul(s3, 4'hd),
              gmul(s0, 4'hd) ^ gmul(s1, 4'h9) ^ gmul(s2, 4'he) ^ gmul(s3, 4'hb),
              gmul(s0, 4'hb) ^ gmul(s1, 4'hd) ^ gmul(s2, 4'h9) ^ gmul(s3, 4'he)};
   endfunction

   assign ready_out = (st_q == IDLE);
   assign valid_out = (st_q == DONE);
   assign state_dbg = st_q;

`ifndef INV_MIX_PARALLEL_EN
   logic [1:0]  col_q;
   logic [31:0] col_in;
   logic [31:0] col_out;

   // Select the input column addressed by the column counter
   always_comb begin
      col_in = '0;
      for (int c = 0; c < 4; c++) begin
         if (col_q == 2'(c)) col_in = blk_q[127-32*c -: 32];
      end
   end

   assign col_out = inv_col(col_in);
`endif

   // State register; reset aborts any block in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) st_q <= IDLE;
      else        st_q <= st_d;
   end

   // Next-state logic
   always_comb begin
      st_d = st_q;
      case (st_q)
         IDLE: if (valid_in) st_d = CALC;
`ifdef INV_MIX_PARALLEL_EN
         CALC: st_d = DONE;
`else
         CALC: if (col_q == 2'd3) st_d = DONE;
`endif
         DONE: if (ready_in) st_d = IDLE;
         default: st_d = IDLE;
      endcase
   end

   // Input capture and column results; data_out holds once written
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blk_q    <= '0;
         data_out <= '0;
`ifndef INV_MIX_PARALLEL_EN
         col_q    <= 2'd0;
`endif
      end else begin
         case (st_q)
            IDLE: begin
               if (valid_in) begin
                  blk_q <= data_in;
`ifndef INV_MIX_PARALLEL_EN
                  col_q <= 2'd0;
`endif
               end
            end
            CALC: begin
`ifdef INV_MIX_PARALLEL_EN
               data_out <= {inv_col(blk_q[127:96]), inv_col(blk_q[95:64]),
                            inv_col(blk_q[63:32]),  inv_col(blk_q[31:0])};
`else
               for (int c = 0; c < 4; c++) begin
                  if (col_q == 2'(c)) data_out[127-32*c -: 32] <= col_out;
               end
               col_q <= col_q + 2'd1;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// tb_inv_mix_columns_iter: directed vectors, backpressure, back-to-back,
// reset mid-block and a forward/inverse MixColumns round trip.
module tb_inv_mix_columns_iter;

`ifdef INV_MIX_PARALLEL_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 4;
`endif
   localparam int B2B = LAT + 2;

   logic         clk;
   logic         reset;
   logic         valid_in;
   logic [127:0] data_in;
   logic         ready_out;
   logic         valid_out;
   logic [127:0] data_out;
   logic         ready_in;
   logic [1:0]   state_dbg;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   logic sb_en  = 1'b0;
   logic [127:0] exp_q[$];

   typedef struct {
      logic [127:0] din;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs[5];

   inv_mix_columns_iter #(.DATA_W(128)) dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .ready_out (ready_out),
      .valid_out (valid_out),
      .data_out  (data_out),
      .ready_in  (ready_in),
      .state_dbg (state_dbg)
   );

   // clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard: every output fire while enabled pops one expected block
   always @(negedge clk) begin
      if (sb_en && reset && valid_out && ready_in) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL sb_unexpected: got %h expected nothing", data_out);
         end else begin
            check("sb_data", data_out, exp_q.pop_front());
         end
      end
   end

   // forward MixColumns model used for the round trip
   function automatic logic [7:0] x2f(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] fwd_mix(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0] a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         r[127-32*c -: 8] = x2f(a0) ^ (x2f(a1) ^ a1) ^ a2 ^ a3;
         r[119-32*c -: 8] = a0 ^ x2f(a1) ^ (x2f(a2) ^ a2) ^ a3;
         r[111-32*c -: 8] = a0 ^ a1 ^ x2f(a2) ^ (x2f(a3) ^ a3);
         r[103-32*c -: 8] = (x2f(a0) ^ a0) ^ a1 ^ a2 ^ x2f(a3);
      end
      return r;
   endfunction

   // driver: present a block and return just after its accept edge
   task automatic send(input logic [127:0] d);
      int n;
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = d;
      n = 0;
      while (!ready_out && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready_out) begin
         n_checks++;
         n_err++;
         $display("FAIL send_timeout: ready_out %b expected 1", ready_out);
      end
      @(posedge clk);
      #1;
      valid_in = 1'b0;
   endtask

   // wait for valid_out after an accept; returns edges counted
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!valid_out && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic drain;
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", 128'(exp_q.size()), 128'd0);
   endtask

   initial begin
      int lat;
      int t0;
      int t1;
      logic [127:0] r;

      vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
      vecs[1] = '{128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 128'hd4d4d4d5_2d26314c_00000000_ffffffff};
      vecs[2] = '{128'h00010000_80000000_01000000_00000001, 128'h0b0e090d_41ecdaf7_0e090d0b_090d0b0e};
      vecs[3] = '{128'h00000000_00000000_00000000_00000000, 128'h00000000_00000000_00000000_00000000};
      vecs[4] = '{128'hffffffff_ffffffff_ffffffff_ffffffff, 128'hffffffff_ffffffff_ffffffff_ffffffff};

      // reset state
      reset    = 1'b0;
      valid_in = 1'b0;
      data_in  = '0;
      ready_in = 1'b0;
      #1;
      check("rst_ready_out", 128'(ready_out), 128'd1);
      check("rst_valid_out", 128'(valid_out), 128'd0);
      check("rst_data_out", data_out, 128'd0);
      check("rst_state", 128'(state_dbg), 128'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // directed vectors with latency and release checks
      for (int i = 0; i < 5; i++) begin
         send(vecs[i].din);
         check("accept_ready_low", 128'(ready_out), 128'd0);
         wait_valid(lat);
         check("latency", 128'(lat), 128'(LAT));
         check("vec_data", data_out, vecs[i].exp);
         @(negedge clk);
         ready_in = 1'b1;
         @(posedge clk);
         #1;
         check("rel_valid_low", 128'(valid_out), 128'd0);
         check("rel_ready_high", 128'(ready_out), 128'd1);
         check("rel_data_hold", data_out, vecs[i].exp);
         ready_in = 1'b0;
      end

      // backpressure: ten stalled cycles with a competing valid_in
      send(vecs[0].din);
      wait_valid(lat);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         valid_in = 1'b1;
         data_in  = vecs[1].din ^ 128'(k);
         @(posedge clk);
         #1;
         check("bp_data_stable", data_out, vecs[0].exp);
         check("bp_ready_low", 128'(ready_out), 128'd0);
         check("bp_valid_high", 128'(valid_out), 128'd1);
      end
      @(negedge clk);
      valid_in = 1'b0;
      ready_in = 1'b1;
      @(posedge clk);
      #1;
      check("bp_rel_valid", 128'(valid_out), 128'd0);
      check("bp_rel_ready", 128'(ready_out), 128'd1);
      check("bp_rel_data", data_out, vecs[0].exp);
      ready_in = 1'b0;

      // back-to-back: valid held high across two blocks
      @(negedge clk);
      sb_en    = 1'b1;
      ready_in = 1'b1;
      exp_q.push_back(vecs[0].exp);
      exp_q.push_back(vecs[1].exp);
      valid_in = 1'b1;
      data_in  = vecs[0].din;
      @(posedge clk);
      #1;
      t0 = cyc;
      data_in = vecs[1].din;
      begin
         int n;
         n = 0;
         @(negedge clk);
         while (!ready_out && n < 40) begin
            @(negedge clk);
            n++;
         end
      end
      @(posedge clk);
      #1;
      t1 = cyc;
      valid_in = 1'b0;
      check("b2b_spacing", 128'(t1 - t0), 128'(B2B));
      drain();
      sb_en    = 1'b0;
      ready_in = 1'b0;

      // reset in the middle of a block
      send(vecs[0].din);
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_valid", 128'(valid_out), 128'd0);
      check("midrst_data", data_out, 128'd0);
      check("midrst_ready", 128'(ready_out), 128'd1);
      @(negedge clk);
      reset = 1'b1;
      send(vecs[1].din);
      wait_valid(lat);
      check("postrst_latency", 128'(lat), 128'(LAT));
      check("postrst_data", data_out, vecs[1].exp);
      @(negedge clk);
      ready_in = 1'b1;
      @(posedge clk);
      #1;

      // round trip through forward MixColumns
      sb_en = 1'b1;
      for (int b = 0; b < 1000; b++) begin
         r = {$urandom, $urandom, $urandom, $urandom};
         exp_q.push_back(r);
         send(fwd_mix(r));
      end
      drain();
      sb_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
      $finish;
   end

   // global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time exceeded limit");
      $fatal(1, "watchdog");
   end

endmodule
